// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage: one shared
// shift-add / restoring shift-subtract datapath, one bit per cycle.
// Optional MULDIV_FASTPATH_EN: trivial operands skip the iteration and retire next cycle.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          op_r;
    logic [XLEN-1:0]     mag_b_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CW-1:0]       cnt_r;
    logic                sign_a_r;
    logic                sign_b_r;
    logic                div0_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic                is_div_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic [XLEN:0]       add_s;
    logic [XLEN:0]       shl_s;
    logic                ge_s;
    logic [XLEN-1:0]     sub_s;
    logic [2*XLEN-1:0]   mul_nxt_s;
    logic [2*XLEN-1:0]   div_nxt_s;
    logic [2*XLEN-1:0]   acc_nxt_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     fix_res_s;
    logic                fast_hit_s;
    logic [XLEN-1:0]     fast_res_s;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Operand signedness and magnitudes for the instruction offered in IDLE.
    always_comb begin
        is_div_s = op[2];
        if (is_div_s) begin
            a_signed_s = ~op[0];
            b_signed_s = ~op[0];
        end else begin
            a_signed_s = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
            b_signed_s = (op[1:0] == 2'b01);
        end
        sign_a_s = a_signed_s & src_a[XLEN-1];
        sign_b_s = b_signed_s & src_b[XLEN-1];
        if (sign_a_s) begin
            mag_a_s = neg_x(src_a);
        end else begin
            mag_a_s = src_a;
        end
        if (sign_b_s) begin
            mag_b_s = neg_x(src_b);
        end else begin
            mag_b_s = src_b;
        end
    end

    // One datapath step: multiply adds into the high half then shifts right;
    // divide shifts the remainder left and subtracts when it fits.
    always_comb begin
        if (acc_r[0]) begin
            add_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, mag_b_r};
        end else begin
            add_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        end
        mul_nxt_s = {add_s, acc_r[XLEN-1:1]};

        shl_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        ge_s  = (shl_s >= {1'b0, mag_b_r});
        sub_s = shl_s[XLEN-1:0] - mag_b_r;
        if (ge_s) begin
            div_nxt_s = {sub_s, acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_nxt_s = {shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end

        if (op_r[2]) begin
            acc_nxt_s = div_nxt_s;
        end else begin
            acc_nxt_s = mul_nxt_s;
        end
    end

    // Sign fix-up on the final step. A zero divisor keeps the all-ones quotient,
    // and the remainder follows the dividend sign, which restores src_a exactly.
    always_comb begin
        if (sign_a_r ^ sign_b_r) begin
            prod_s = neg_2x(acc_nxt_s);
        end else begin
            prod_s = acc_nxt_s;
        end
        if ((sign_a_r ^ sign_b_r) && !div0_r) begin
            quot_s = neg_x(acc_nxt_s[XLEN-1:0]);
        end else begin
            quot_s = acc_nxt_s[XLEN-1:0];
        end
        if (sign_a_r) begin
            rem_s = neg_x(acc_nxt_s[2*XLEN-1:XLEN]);
        end else begin
            rem_s = acc_nxt_s[2*XLEN-1:XLEN];
        end
        case (op_r)
            3'b000:                 fix_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = quot_s;
            3'b110, 3'b111:         fix_res_s = rem_s;
            default:                fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Early-retire detection for operands whose result is known up front.
    always_comb begin
`ifdef MULDIV_FASTPATH_EN
        if (is_div_s && (src_b == {XLEN{1'b0}})) begin
            fast_hit_s = 1'b1;
            if (op[1]) begin
                fast_res_s = src_a;
            end else begin
                fast_res_s = {XLEN{1'b1}};
            end
        end else if (is_div_s && !op[0] &&
                     (src_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (src_b == {XLEN{1'b1}})) begin
            fast_hit_s = 1'b1;
            if (op[1]) begin
                fast_res_s = {XLEN{1'b0}};
            end else begin
                fast_res_s = src_a;
            end
        end else if (!is_div_s &&
                     ((src_a == {XLEN{1'b0}}) || (src_b == {XLEN{1'b0}}))) begin
            fast_hit_s = 1'b1;
            fast_res_s = {XLEN{1'b0}};
        end else begin
            fast_hit_s = 1'b0;
            fast_res_s = {XLEN{1'b0}};
        end
`else
        fast_hit_s = 1'b0;
        fast_res_s = {XLEN{1'b0}};
`endif
    end

    // Sequencer FSM with registered done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 3'b000;
            mag_b_r  <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= {CW{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            div0_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r   <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                    if (start && !flush) begin
                        op_r     <= op;
                        mag_b_r  <= mag_b_s;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        div0_r   <= (src_b == {XLEN{1'b0}});
                        if (fast_hit_s) begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            result_r <= fast_res_s;
                        end else begin
                            acc_r   <= {{XLEN{1'b0}}, mag_a_s};
                            cnt_r   <= CNT_INIT;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_r <= IDLE;
                        acc_r   <= {(2*XLEN){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        done_r  <= 1'b0;
                    end else begin
                        acc_r <= acc_nxt_s;
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            result_r <= fix_res_s;
                        end
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    done_r   <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                end
                default: begin
                    state_r  <= IDLE;
                    done_r   <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                end
            endcase
        end
    end

    // Freeze request: a fresh accept in IDLE, or any cycle spent iterating.
    always_comb begin
        if (state_r == CALC) begin
            stall = 1'b1;
        end else if (state_r == IDLE) begin
            stall = start & ~flush;
        end else begin
            stall = 1'b0;
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq (XLEN=32); honours MULDIV_FASTPATH_EN.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_FASTPATH_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Drives one instruction (start held for cycle 0 only) and measures, over 60 cycles.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int dcyc, output logic [31:0] res, output int stall_n,
                         output int done_n, output logic [31:0] res_after);
        dcyc = -1; res = 32'hDEADBEEF; res_after = 32'hDEADBEEF;
        stall_n = 0; done_n = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 1) start = 1'b0;
            #1;
            if (stall) stall_n++;
            if (dcyc >= 0 && c == dcyc + 1) res_after = result;
            if (done) begin
                done_n++;
                if (dcyc < 0) begin
                    dcyc = c;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #2;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got=%h exp=0", result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #2;
        checks++; if (done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL post_rst_idle got done=%b result=%h exp 0/0", done, result);
        end
    endtask

    task automatic test_table(input string name, input vec_t tv[8], input int n);
        int d, s, dn;
        logic [31:0] r, ra;
        for (int i = 0; i < n; i++) begin
            issue(tv[i].op, tv[i].a, tv[i].b, d, r, s, dn, ra);
            checks++; if (r !== tv[i].exp) begin errors++; $display("FAIL %s[%0d]_result got=%h exp=%h", name, i, r, tv[i].exp); end
            checks++; if (d !== tv[i].lat) begin errors++; $display("FAIL %s[%0d]_done_cycle got=%0d exp=%0d", name, i, d, tv[i].lat); end
            checks++; if (s !== tv[i].lat) begin errors++; $display("FAIL %s[%0d]_stall_cycles got=%0d exp=%0d", name, i, s, tv[i].lat); end
            checks++; if (dn !== 1) begin errors++; $display("FAIL %s[%0d]_done_pulses got=%0d exp=1", name, i, dn); end
            checks++; if (ra !== 32'd0) begin errors++; $display("FAIL %s[%0d]_result_idle got=%h exp=0", name, i, ra); end
        end
    endtask

    task automatic test_mul;
        vec_t tv[8];
        tv[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        tv[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tv[2] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        tv[3] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        tv[4] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
        tv[5] = '{3'b001, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 33};
        tv[6] = tv[0]; tv[7] = tv[0];
        test_table("mul", tv, 6);
    endtask

    task automatic test_div;
        vec_t tv[8];
        tv[0] = '{3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 33};
        tv[1] = '{3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 33};
        tv[2] = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        tv[3] = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        tv[4] = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33};
        tv[5] = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'd2,        33};
        tv[6] = tv[0]; tv[7] = tv[0];
        test_table("div", tv, 6);
    endtask

    task automatic test_special;
        vec_t tv[8];
        tv[0] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SP_LAT};
        tv[1] = '{3'b111, 32'd5,        32'd0,        32'd5,        SP_LAT};
        tv[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SP_LAT};
        tv[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SP_LAT};
        tv[4] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, SP_LAT};
        tv[5] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, SP_LAT};
        tv[6] = '{3'b000, 32'd0,        32'd12345,    32'd0,        SP_LAT};
        tv[7] = '{3'b001, 32'hFFFFFFFF, 32'd0,        32'd0,        SP_LAT};
        test_table("special", tv, 8);
    endtask

    task automatic test_flush;
        int d = -1, dn = 0;
        logic [31:0] r = 32'hDEADBEEF;
        logic st10 = 1'b0, st11 = 1'b1;
        // flush alongside start in IDLE: nothing accepted
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101; src_a = 32'd100; src_b = 32'd7; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
        @(posedge clk); #1; start = 1'b0; flush = 1'b0; #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle_state got stall=%b done=%b exp 0/0", stall, done);
        end
        // flush during CALC, then a fresh start at cycle 12
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101; src_a = 32'd100; src_b = 32'd7;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 1) start = 1'b0;
            if (c == 10) flush = 1'b1;
            if (c == 11) flush = 1'b0;
            if (c == 12) begin start = 1'b1; op = 3'b101; src_a = 32'd100; src_b = 32'd7; end
            if (c == 13) start = 1'b0;
            #1;
            if (c == 10) st10 = stall;
            if (c == 11) st11 = stall;
            if (done) begin
                dn++;
                if (d < 0) begin d = c; r = result; end
            end
        end
        checks++; if (st10 !== 1'b1) begin errors++; $display("FAIL flush_c10_stall got=%b exp=1", st10); end
        checks++; if (st11 !== 1'b0) begin errors++; $display("FAIL flush_c11_stall got=%b exp=0", st11); end
        checks++; if (d !== 45) begin errors++; $display("FAIL flush_restart_done_cycle got=%0d exp=45", d); end
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL flush_restart_result got=%h exp=%h", r, 32'd14); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL flush_done_pulses got=%0d exp=1", dn); end
    endtask

    task automatic test_reset_mid;
        int dn = 0;
        logic st4 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; src_a = 32'd7; src_b = 32'hFFFFFFFD;
        for (int c = 0; c < 50; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 1) start = 1'b0;
            if (c == 5) rst_n = 1'b0;
            #1;
            if (c == 4) st4 = stall;
            if (c == 5) begin
                checks++; if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
                    errors++; $display("FAIL rstmid_outputs got stall=%b done=%b result=%h exp 0/0/0", stall, done, result);
                end
                #2; rst_n = 1'b1;
            end
            if (done) dn++;
        end
        checks++; if (st4 !== 1'b1) begin errors++; $display("FAIL rstmid_c4_stall got=%b exp=1", st4); end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_done_pulses got=%0d exp=0", dn); end
    endtask

    task automatic test_back_to_back;
        int d1 = -1, d2 = -1, dn = 0;
        logic [31:0] r1 = 32'hDEADBEEF, r2 = 32'hDEADBEEF;
        logic st33 = 1'b1, st34 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; src_a = 32'd7; src_b = 32'hFFFFFFFD;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 34) begin op = 3'b101; src_a = 32'd100; src_b = 32'd7; end
            if (c == 35) start = 1'b0;
            #1;
            if (c == 33) st33 = stall;
            if (c == 34) st34 = stall;
            if (done) begin
                dn++;
                if (d1 < 0) begin d1 = c; r1 = result; end
                else if (d2 < 0) begin d2 = c; r2 = result; end
            end
        end
        checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=2", dn); end
        checks++; if (d1 !== 33 || r1 !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL b2b_first got cycle=%0d result=%h exp 33/%h", d1, r1, 32'hFFFFFFEB);
        end
        checks++; if (d2 !== 67 || r2 !== 32'd14) begin
            errors++; $display("FAIL b2b_second got cycle=%0d result=%h exp 67/%h", d2, r2, 32'd14);
        end
        checks++; if (st33 !== 1'b0) begin errors++; $display("FAIL b2b_done_stall got=%b exp=0", st33); end
        checks++; if (st34 !== 1'b1) begin errors++; $display("FAIL b2b_accept_stall got=%b exp=1", st34); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
